core_nios2_mult_unit: RTL and testbench
=======================================

# core_nios2_mult_unit

Parametrised, pipelined integer multiply unit for the Nios II core. Supersedes the fixed 32-bit low-word multiply cell. Adds:
- Operand width as a parameter.
- Nios II high-word modes (MULXSS/MULXSU/MULXUU).
- A valid/ready handshake with backpressure and a synchronous flush.

It sits between the A-stage operand muxes and the writeback result mux.

## Interface
- DATA_W, 32, operand and result width; a multiple of SLICE_W, range 16..64.
- SLICE_W, 16, width of each partial-product multiplier slice.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_op  in  2  mode: 0 MUL, 1 MULXSS, 2 MULXSU, 3 MULXUU.
- in_src1  in  DATA_W  operand A.
- in_src2  in  DATA_W  operand B.
- in_tag  in  5  destination register tag, carried alongside the data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  result.
- out_tag  out  5  tag of the result.

## Operation
- Three pipeline stages:
  - S1 registers operands, op and tag.
  - S2 registers all (DATA_W/SLICE_W)^2 unsigned SLICE_W×SLICE_W partial products, plus the sign-correction terms.
  - S3 sums the shifted partial products, applies the correction, selects the word and registers it into out_result.
- Arithmetic, with P the exact 2·DATA_W-bit product:
  - MUL: out_result = P[DATA_W-1:0], computed as unsigned.
  - MULXUU: P[2·DATA_W-1:DATA_W], both operands unsigned.
  - MULXSS: both operands signed.
  - MULXSU: src1 signed, src2 unsigned.
  - Signed high word = unsigned high word − (src1 msb ? src2 : 0)[signed op] − (src2 msb ? src1 : 0)[src2 signed only], taken modulo 2^DATA_W.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- stall = out_valid && !out_ready. While stalled, every stage holds its contents.
- in_ready = !stall && !flush.
- flush has priority over everything:
  - Clears all stage valids on the next edge.
  - No beat is accepted in the flush cycle.
  - Data registers may keep stale values.
- Bubbles are allowed: an empty stage advances even while a later stage holds data, provided the unit is not stalled.

## Timing
- Latency: a beat accepted at edge N produces out_valid at edge N+3 when there is no stall.
- Throughput: one beat per cycle.
- Reset values (asynchronous assert, synchronous release):
  - All stage valids 0 and out_valid 0.
  - out_result 0 and out_tag 0.
  - in_ready is combinational and reads 1 during reset.
- Reset asserted mid-operation discards all in-flight beats; the first output after release comes from a beat accepted after release.
- out_valid stays high and out_result/out_tag stay stable until out_ready is sampled high.
- Stall boundary: when out_ready drops with 3 beats in flight, all 3 are held. No beat is lost or duplicated, and the beats drain in order once out_ready rises.
- Simultaneous flush and out_ready: the result presented in that cycle counts as consumed, and out_valid goes to 0 on the next edge.

## Structure
- Package core_nios2_mult_pkg holds:
  - Op encoding constants: MUL_OP_LO, MUL_OP_XSS, MUL_OP_XSU, MUL_OP_XUU.
  - MULT_LATENCY = 3.
  - TAG_W = 5.
- Sub-module core_nios2_mult_slice: one registered unsigned SLICE_W×SLICE_W multiplier with enable and asynchronous clear. It is instantiated (DATA_W/SLICE_W)^2 times in a generate loop so that synthesis maps each instance onto a dedicated DSP block.

## Test plan
- Reset then MUL, 0x00001234 × 0x00005678 → 0x06260060 three cycles after acceptance; out_valid was 0 throughout reset.
- Back-to-back beats with src1 = src2 = 0xFFFFFFFF and op MUL, XUU, XSS, XSU in order → 0x00000001, 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF on consecutive cycles, with tags 1, 2, 3, 4 preserved.
- MULXSS 0x80000000 × 0x80000000 → 0x40000000; MULXSU 0x80000000 × 0x00000002 → 0xFFFFFFFF.
- Backpressure: stream 6 beats and hold out_ready = 0 for 5 cycles starting at the first out_valid → in_ready falls; 6 results in order with no loss or duplication.
- flush asserted with 3 beats in flight and in_valid = 1 → in_ready = 0 that cycle; out_valid = 0 for the next 3 cycles; the next accepted beat appears 3 cycles after acceptance.
- reset_n pulsed low asynchronously mid-stream → out_valid drops immediately; after release no stale result appears.
- DATA_W = 64 instance, MULXUU 0xFFFFFFFFFFFFFFFF × 0x2 → 0x0000000000000001.

Source files
------------

// File: rtl/core_nios2_mult_pkg.sv
// Shared constants for the Nios II multiply unit: op encodings, pipeline depth, tag width.
package core_nios2_mult_pkg;

   localparam logic [1:0] MUL_OP_LO  = 2'd0;
   localparam logic [1:0] MUL_OP_XSS = 2'd1;
   localparam logic [1:0] MUL_OP_XSU = 2'd2;
   localparam logic [1:0] MUL_OP_XUU = 2'd3;

   localparam int MULT_LATENCY = 3;
   localparam int TAG_W        = 5;

   typedef logic [TAG_W-1:0] tag_t;

   function automatic logic op_src1_signed(input logic [1:0] op);
      return (op == MUL_OP_XSS) || (op == MUL_OP_XSU);
   endfunction

endpackage

// File: rtl/core_nios2_mult_slice.sv
// One registered unsigned SLICE_W x SLICE_W multiplier; kept as its own module so each maps to a DSP.
module core_nios2_mult_slice
   import core_nios2_mult_pkg::*;
#(
   parameter int SLICE_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic [SLICE_W-1:0]     a,
   input  logic [SLICE_W-1:0]     b,
   output logic [2*SLICE_W-1:0]   p
);

   logic [2*SLICE_W-1:0] p_q;
   logic [2*SLICE_W-1:0] p_d;

   always_comb begin
      p_d = p_q;
      if (en) begin
         p_d = (2*SLICE_W)'(a) * (2*SLICE_W)'(b);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/core_nios2_mult_unit.sv
// Three-stage pipelined multiply (low word and signed/unsigned high word) with valid/ready and flush.
module core_nios2_mult_unit
   import core_nios2_mult_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int NS  = DATA_W / SLICE_W;
   localparam int NPP = NS * NS;
   localparam int PW  = 2 * DATA_W;

   logic stall, adv, accept, pp_en;

   logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [DATA_W-1:0] a1_q, a1_d, b1_q, b1_d;
   logic [1:0]        op1_q, op1_d, op2_q, op2_d;
   tag_t              tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic [DATA_W-1:0] corr2_q, corr2_d;
   logic [DATA_W-1:0] res_q, res_d;

   logic [2*SLICE_W-1:0] pp [NPP];
   logic [DATA_W-1:0]    corr;
   logic [PW-1:0]        sum;
   logic [DATA_W-1:0]    hi_word;

   assign stall    = v3_q && !out_ready;
   assign adv      = !stall;
   assign in_ready = !stall && !flush;
   assign accept   = in_valid && in_ready;
   assign pp_en    = adv && v1_q;

   for (genvar gi = 0; gi < NS; gi++) begin : g_row
      for (genvar gj = 0; gj < NS; gj++) begin : g_col
         core_nios2_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (pp_en),
            .a       (a1_q[gi*SLICE_W +: SLICE_W]),
            .b       (b1_q[gj*SLICE_W +: SLICE_W]),
            .p       (pp[gi*NS + gj])
         );
      end
   end

   // Signed high word = unsigned high word minus the operand-msb correction terms.
   always_comb begin
      corr = '0;
      if (op_src1_signed(op1_q) && a1_q[DATA_W-1]) begin
         corr = corr + b1_q;
      end
      if ((op1_q == MUL_OP_XSS) && b1_q[DATA_W-1]) begin
         corr = corr + a1_q;
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < NS; i++) begin
         for (int j = 0; j < NS; j++) begin
            sum = sum + (PW'(pp[i*NS + j]) << ((i + j) * SLICE_W));
         end
      end
      hi_word = sum[PW-1:DATA_W] - corr2_q;
   end

   always_comb begin
      v1_d    = v1_q;
      v2_d    = v2_q;
      v3_d    = v3_q;
      a1_d    = a1_q;
      b1_d    = b1_q;
      op1_d   = op1_q;
      tag1_d  = tag1_q;
      op2_d   = op2_q;
      tag2_d  = tag2_q;
      corr2_d = corr2_q;
      res_d   = res_q;
      tag3_d  = tag3_q;

      if (flush) begin
         v1_d = 1'b0;
         v2_d = 1'b0;
         v3_d = 1'b0;
      end else if (adv) begin
         v1_d = accept;
         v2_d = v1_q;
         v3_d = v2_q;
      end

      if (accept) begin
         a1_d   = in_src1;
         b1_d   = in_src2;
         op1_d  = in_op;
         tag1_d = in_tag;
      end

      if (adv && v1_q) begin
         op2_d   = op1_q;
         tag2_d  = tag1_q;
         corr2_d = corr;
      end

      if (adv && v2_q) begin
         res_d  = (op2_q == MUL_OP_LO) ? sum[DATA_W-1:0] : hi_word;
         tag3_d = tag2_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         op1_q   <= MUL_OP_LO;
         tag1_q  <= '0;
         op2_q   <= MUL_OP_LO;
         tag2_q  <= '0;
         corr2_q <= '0;
         res_q   <= '0;
         tag3_q  <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         op1_q   <= op1_d;
         tag1_q  <= tag1_d;
         op2_q   <= op2_d;
         tag2_q  <= tag2_d;
         corr2_q <= corr2_d;
         res_q   <= res_d;
         tag3_q  <= tag3_d;
      end
   end

   assign out_valid  = v3_q;
   assign out_result = res_q;
   assign out_tag    = tag3_q;

endmodule

// File: tb/tb_core_nios2_mult_unit.sv
// Bench for core_nios2_mult_unit: product model + scoreboard checked every cycle, plus directed literals.
module tb_core_nios2_mult_unit;
   import core_nios2_mult_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;

   logic        w_in_valid;
   logic        w_in_ready;
   logic [1:0]  w_in_op;
   logic [63:0] w_in_src1;
   logic [63:0] w_in_src2;
   logic [4:0]  w_in_tag;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [63:0] w_out_result;
   logic [4:0]  w_out_tag;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   core_nios2_mult_unit #(.DATA_W(32), .SLICE_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   core_nios2_mult_unit #(.DATA_W(64), .SLICE_W(16)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .flush(1'b0),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
      .in_src1(w_in_src1), .in_src2(w_in_src2), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_result(w_out_result), .out_tag(w_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Reference product straight from the definition: full-width signed/unsigned multiply, pick a word.
   function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0]        ua, ub, p;
      logic signed [63:0] sa, sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      case (op)
         MUL_OP_LO:  p = ua * ub;
         MUL_OP_XUU: p = ua * ub;
         MUL_OP_XSS: p = sa * sb;
         default:    p = sa * $signed(ub);
      endcase
      return (op == MUL_OP_LO) ? p[31:0] : p[63:32];
   endfunction

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] got_res[$];
   logic [4:0]  got_tag[$];
   int          got_lat[$];
   int          got_cyc[$];

   logic        prev_stall = 1'b0;
   logic [31:0] prev_res;
   logic [4:0]  prev_tag;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", {63'd0, out_valid}, 64'd1);
               chk("hold_result", {32'd0, out_result}, {32'd0, prev_res});
               chk("hold_tag", {59'd0, out_tag}, {59'd0, prev_tag});
            end
            if (out_valid) begin
               chk("no_spurious_out", {63'd0, (q.size() > 0)}, 64'd1);
               if (out_ready && q.size() > 0) begin
                  e = q.pop_front();
                  chk("model_result", {32'd0, out_result}, {32'd0, e.res});
                  chk("model_tag", {59'd0, out_tag}, {59'd0, e.tag});
                  chk("latency_min", {63'd0, ((cyc - e.acc) >= MULT_LATENCY)}, 64'd1);
                  got_res.push_back(out_result);
                  got_tag.push_back(out_tag);
                  got_lat.push_back(cyc - e.acc);
                  got_cyc.push_back(cyc);
               end
            end
            chk("in_ready_rule", {63'd0, in_ready},
                {63'd0, (!(out_valid && !out_ready) && !flush)});
            prev_stall = out_valid && !out_ready && !flush;
            prev_res   = out_result;
            prev_tag   = out_tag;
            if (flush) begin
               q.delete();
            end else if (in_valid && in_ready) begin
               e.res = model_res(in_op, in_src1, in_src2);
               e.tag = in_tag;
               e.acc = cyc;
               q.push_back(e);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
      logic ok;
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      in_tag   = tag;
      ok       = 1'b0;
      for (int g = 0; g < 200 && !ok; g++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
         @(posedge clk);
         #1;
         done = (q.size() == 0) && !out_valid;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   logic [1:0]  v_op[8];
   logic [31:0] v_a[8];
   logic [31:0] v_b[8];
   logic [31:0] v_exp[8];
   logic [4:0]  v_tag[8];

   task automatic set_v(input int k, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
      v_op[k]  = op;
      v_a[k]   = a;
      v_b[k]   = b;
      v_tag[k] = tag;
      v_exp[k] = exp;
   endtask

   task automatic check_got(input int base, input int n, input bit exact_timing);
      chk("result_count", 64'(got_res.size() - base), 64'(n));
      if (got_res.size() - base == n) begin
         for (int k = 0; k < n; k++) begin
            chk("lit_result", {32'd0, got_res[base+k]}, {32'd0, v_exp[k]});
            chk("lit_tag", {59'd0, got_tag[base+k]}, {59'd0, v_tag[k]});
            if (exact_timing) begin
               chk("lit_latency", 64'(got_lat[base+k]), 64'd3);
               chk("lit_consecutive", 64'(got_cyc[base+k] - got_cyc[base]), 64'(k));
            end
         end
      end
   endtask

   task automatic run_b2b(input int n);
      int base;
      base = got_res.size();
      for (int k = 0; k < n; k++) send(v_op[k], v_a[k], v_b[k], v_tag[k]);
      in_valid = 1'b0;
      wait_drain();
      check_got(base, n, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int base;
      logic seen;
      reset_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_op = 2'd0;
      in_src1 = '0;
      in_src2 = '0;
      in_tag = '0;
      out_ready = 1'b1;
      w_in_valid = 1'b0;
      w_in_op = 2'd0;
      w_in_src1 = '0;
      w_in_src2 = '0;
      w_in_tag = '0;
      w_out_ready = 1'b1;

      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_out_result", {32'd0, out_result}, 64'd0);
         chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
         chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      end
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single MUL, exact cycle-by-cycle latency.
      in_valid = 1'b1;
      in_op = MUL_OP_LO;
      in_src1 = 32'h0000_1234;
      in_src2 = 32'h0000_5678;
      in_tag = 5'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t1_valid_n0", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("t1_valid_n1", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("t1_valid_n2", {63'd0, out_valid}, 64'd1);
      chk("t1_result", {32'd0, out_result}, 64'h0626_0060);
      chk("t1_tag", {59'd0, out_tag}, 64'd5);
      @(posedge clk);
      #1;
      chk("t1_consumed", {63'd0, out_valid}, 64'd0);

      // Back-to-back, all four modes on all-ones operands.
      set_v(0, MUL_OP_LO,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
      set_v(1, MUL_OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
      set_v(2, MUL_OP_XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000);
      set_v(3, MUL_OP_XSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
      run_b2b(4);

      // Most-negative operand corners.
      set_v(0, MUL_OP_XSS, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000);
      set_v(1, MUL_OP_XSU, 32'h8000_0000, 32'h0000_0002, 5'd9, 32'hFFFF_FFFF);
      set_v(2, MUL_OP_XSU, 32'h7FFF_FFFF, 32'h8000_0000, 5'd10, 32'h3FFF_FFFF);
      run_b2b(3);

      // Backpressure: six beats, out_ready low for five cycles from the first out_valid.
      set_v(0, MUL_OP_LO,  32'h0000_0002, 32'h0000_0003, 5'd1, 32'h0000_0006);
      set_v(1, MUL_OP_XUU, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0001);
      set_v(2, MUL_OP_XSS, 32'hFFFF_FFFE, 32'h0000_0003, 5'd3, 32'hFFFF_FFFF);
      set_v(3, MUL_OP_XSS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000);
      set_v(4, MUL_OP_LO,  32'h0000_FFFF, 32'h0000_FFFF, 5'd5, 32'hFFFE_0001);
      set_v(5, MUL_OP_XSU, 32'hFFFF_FFF0, 32'h0000_0010, 5'd6, 32'hFFFF_FFFF);
      base = got_res.size();
      fork
         begin
            for (int k = 0; k < 6; k++) send(v_op[k], v_a[k], v_b[k], v_tag[k]);
            in_valid = 1'b0;
         end
         begin
            seen = 1'b0;
            for (int g = 0; g < 50 && !seen; g++) begin
               @(posedge clk);
               #1;
               seen = out_valid;
            end
            chk("bp_first_valid", {63'd0, seen}, 64'd1);
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check_got(base, 6, 1'b0);

      // Flush with three beats in flight and a beat offered in the flush cycle.
      base = got_res.size();
      send(MUL_OP_LO, 32'd3, 32'd5, 5'd11);
      send(MUL_OP_LO, 32'd4, 32'd5, 5'd12);
      send(MUL_OP_LO, 32'd6, 32'd5, 5'd13);
      in_valid = 1'b1;
      in_src1 = 32'd9;
      in_src2 = 32'd9;
      in_tag = 5'd14;
      flush = 1'b1;
      #1;
      chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
      chk("fl_presented", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("fl_valid_c1", {63'd0, out_valid}, 64'd0);
      in_op = MUL_OP_LO;
      in_src1 = 32'd7;
      in_src2 = 32'd6;
      in_tag = 5'd17;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("fl_valid_c2", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("fl_valid_c3", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("fl_next_valid", {63'd0, out_valid}, 64'd1);
      chk("fl_next_result", {32'd0, out_result}, 64'h2A);
      chk("fl_next_tag", {59'd0, out_tag}, 64'd17);
      wait_drain();
      chk("fl_count", 64'(got_res.size() - base), 64'd2);
      if (got_res.size() - base == 2) begin
         chk("fl_consumed_res", {32'd0, got_res[base]}, 64'd15);
         chk("fl_consumed_tag", {59'd0, got_tag[base]}, 64'd11);
      end

      // Asynchronous reset in mid-stream.
      send(MUL_OP_XUU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20);
      send(MUL_OP_LO, 32'h0000_0100, 32'h0000_0100, 5'd21);
      send(MUL_OP_XSS, 32'hFFFF_0000, 32'h0001_0000, 5'd22);
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_out_result", {32'd0, out_result}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("ar_no_stale", {63'd0, out_valid}, 64'd0);
      end
      set_v(0, MUL_OP_LO, 32'h0000_0010, 32'h0000_0011, 5'd23, 32'h0000_0110);
      run_b2b(1);

      // 64-bit instance.
      w_in_valid = 1'b1;
      w_in_op = MUL_OP_XUU;
      w_in_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
      w_in_src2 = 64'h2;
      w_in_tag = 5'd30;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      chk("w64_valid_n0", {63'd0, w_out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("w64_valid_n1", {63'd0, w_out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("w64_valid_n2", {63'd0, w_out_valid}, 64'd1);
      chk("w64_result", w_out_result, 64'h0000_0000_0000_0001);
      chk("w64_tag", {59'd0, w_out_tag}, 64'd30);

      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
